// File: rtl/mul_seq_ct_pkg.sv
// mul_seq_pkg: shared state encoding and sign helpers for the sequential multiplier.
// Helpers work on a 64-bit word; callers truncate, so WIDTH is limited to 32.
package mul_seq_pkg;
    localparam int MAX_W = 64;
    typedef logic [MAX_W-1:0] word_t;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;
    // x must arrive sign-extended so its top bit is the operand sign
    function automatic word_t mag(word_t x, logic signed_en);
        return (signed_en && x[MAX_W-1]) ? -x : x;
    endfunction
    function automatic word_t apply_sign(word_t p, logic neg);
        return neg ? -p : p;
    endfunction
endpackage

// File: rtl/mul_seq_ct_if.sv
// mul_seq_ct_if: operand/result handshakes plus exported state for miter predicates.
interface mul_seq_ct_if #(parameter int WIDTH = 8);
    localparam int CNT_W = $clog2(WIDTH + 1);
    logic               in_valid, in_ready, op_signed, ct_mode, stall;
    logic               out_valid, out_ready, finish_next;
    logic [WIDTH-1:0]   a, b, b_q, b_q_next;
    logic [2*WIDTH-1:0] o, a_q, acc_q, a_q_next, acc_q_next;
    logic [CNT_W:0]     cycles;
    modport slave (
        input  in_valid, a, b, op_signed, ct_mode, stall, out_ready,
        output in_ready, out_valid, o, cycles, a_q, b_q, acc_q,
               a_q_next, b_q_next, acc_q_next, finish_next
    );
    modport master (
        output in_valid, a, b, op_signed, ct_mode, stall, out_ready,
        input  in_ready, out_valid, o, cycles, a_q, b_q, acc_q,
               a_q_next, b_q_next, acc_q_next, finish_next
    );
endinterface

// File: rtl/mul_seq_ct_datapath.sv
// mul_seq_ct_datapath: shift-and-add magnitude registers, iteration counter and termination test.
module mul_seq_ct_datapath #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_i,
    input  logic               load_i,
    input  logic               step_i,
    input  logic               ct_i,
    input  logic [WIDTH-1:0]   a_mag_i,
    input  logic [WIDTH-1:0]   b_mag_i,
    output logic [2*WIDTH-1:0] a_q_o,
    output logic [2*WIDTH-1:0] acc_q_o,
    output logic [2*WIDTH-1:0] a_d_o,
    output logic [2*WIDTH-1:0] acc_d_o,
    output logic [WIDTH-1:0]   b_q_o,
    output logic [WIDTH-1:0]   b_d_o,
    output logic [CNT_W-1:0]   cnt_q_o,
    output logic               term_o
);
    logic [2*WIDTH-1:0] a_q, a_d, acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    always_comb begin
        a_d    = load_i ? {{WIDTH{1'b0}}, a_mag_i} : step_i ? a_q << 1 : a_q;
        b_d    = load_i ? b_mag_i : step_i ? b_q >> 1 : b_q;
        acc_d  = load_i ? '0 : step_i ? acc_q + (b_q[0] ? a_q : '0) : acc_q;
        cnt_d  = load_i ? '0 : step_i ? cnt_q + CNT_W'(1) : cnt_q;
        term_o = (cnt_q == CNT_W'(WIDTH)) || (!ct_i && (a_q == '0 || b_q == '0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (!stall_i) begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign a_q_o   = a_q;
    assign b_q_o   = b_q;
    assign acc_q_o = acc_q;
    assign cnt_q_o = cnt_q;
    assign a_d_o   = a_d;
    assign b_d_o   = b_d;
    assign acc_d_o = acc_d;
endmodule

// File: rtl/mul_seq_ct.sv
// mul_seq_ct: sequential signed/unsigned multiplier with optional constant-time iteration count.
// Top holds the FSM, handshakes, stall mux and the signed result register.
module mul_seq_ct
    import mul_seq_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input logic         clk,
    input logic         rst,
    mul_seq_ct_if.slave bus
);
    state_t             state_q, state_d;
    logic               accept, step, term, neg_q, neg_d, ct_q, ct_d;
    logic [2*WIDTH-1:0] o_q, o_d;
    logic [CNT_W:0]     cycles_q, cycles_d;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_mag, b_mag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = bus.stall ? state_q :
                  (state_q == ST_IDLE && bus.in_valid) ? ST_BUSY :
                  (state_q == ST_BUSY && term)          ? ST_DONE :
                  (state_q == ST_DONE && bus.out_ready) ? ST_IDLE : state_q;
    end

    always_comb begin
        bus.in_ready    = state_q == ST_IDLE && !bus.stall;
        bus.out_valid   = state_q == ST_DONE;
        bus.finish_next = state_q == ST_BUSY && term;
        accept          = state_q == ST_IDLE && !bus.stall && bus.in_valid;
        step            = state_q == ST_BUSY && !term;
    end

    always_comb begin
        a_mag    = WIDTH'(mag(word_t'($signed(bus.a)), bus.op_signed));
        b_mag    = WIDTH'(mag(word_t'($signed(bus.b)), bus.op_signed));
        neg_d    = accept ? bus.op_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]) : neg_q;
        ct_d     = accept ? bus.ct_mode : ct_q;
        o_d      = bus.finish_next ? (2*WIDTH)'(apply_sign(word_t'(bus.acc_q), neg_q)) : o_q;
        cycles_d = bus.finish_next ? (CNT_W+1)'(cnt) + (CNT_W+1)'(1) : cycles_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_q    <= 1'b0;
            ct_q     <= 1'b0;
            o_q      <= '0;
            cycles_q <= '0;
        end else if (!bus.stall) begin
            neg_q    <= neg_d;
            ct_q     <= ct_d;
            o_q      <= o_d;
            cycles_q <= cycles_d;
        end
    end

    assign bus.o      = o_q;
    assign bus.cycles = cycles_q;

    mul_seq_ct_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk     (clk),
        .rst     (rst),
        .stall_i (bus.stall),
        .load_i  (accept),
        .step_i  (step),
        .ct_i    (ct_q),
        .a_mag_i (a_mag),
        .b_mag_i (b_mag),
        .a_q_o   (bus.a_q),
        .acc_q_o (bus.acc_q),
        .a_d_o   (bus.a_q_next),
        .acc_d_o (bus.acc_q_next),
        .b_q_o   (bus.b_q),
        .b_d_o   (bus.b_q_next),
        .cnt_q_o (cnt),
        .term_o  (term)
    );
endmodule

// File: tb/tb_mul_seq_ct.sv
// tb_mul_seq_ct: directed and random operations checked against an arithmetic product/latency model.
module tb_mul_seq_ct;
    localparam int W = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mul_seq_ct_if #(.WIDTH(W)) bus();
    mul_seq_ct #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int magn(logic [7:0] x, logic s);
        return (s && x[7]) ? 256 - int'(x) : int'(x);
    endfunction

    function automatic logic [15:0] model_prod(logic [7:0] a, logic [7:0] b, logic s);
        int p;
        p = s ? int'($signed(a)) * int'($signed(b)) : int'(a) * int'(b);
        return 16'(p);
    endfunction

    function automatic int model_cycles(logic [7:0] a, logic [7:0] b, logic s, logic ct);
        int ma, mb, k;
        ma = magn(a, s);
        mb = magn(b, s);
        if (ct) return W + 1;
        if (ma == 0 || mb == 0) return 1;
        k = 0;
        while ((mb >> k) != 0) k++;
        return k + 1;
    endfunction

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic s, input logic ct,
                          input int stall_at, input int hold);
        int n, fin, ma, mb, exp_cyc, exp_lat;
        logic [15:0] exp_o;
        ma      = magn(ta, s);
        mb      = magn(tb_v, s);
        exp_cyc = model_cycles(ta, tb_v, s, ct);
        exp_o   = model_prod(ta, tb_v, s);
        exp_lat = exp_cyc + (stall_at >= 0 ? 3 : 0);
        bus.a = ta; bus.b = tb_v; bus.op_signed = s; bus.ct_mode = ct; bus.in_valid = 1'b1;
        chk("in_ready_idle", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.a = 8'($urandom); bus.b = 8'($urandom);
        n = 0; fin = 0;
        while (!bus.out_valid && n < 200) begin
            fin += int'(bus.finish_next);
            if (n == stall_at) begin
                bus.stall = 1'b1;
                repeat (3) begin
                    @(posedge clk); #1; n++;
                    chk("stall_a_q", 64'(bus.a_q), 64'(ma << stall_at));
                    chk("stall_b_q", 64'(bus.b_q), 64'(mb >> stall_at));
                    chk("stall_acc_q", 64'(bus.acc_q), 64'(ma * (mb % (1 << stall_at))));
                end
                bus.stall = 1'b0;
            end
            @(posedge clk); #1; n++;
        end
        bus.in_valid = 1'b0;
        chk("latency", 64'(n), 64'(exp_lat));
        chk("product", 64'(bus.o), 64'(exp_o));
        chk("cycles", 64'(bus.cycles), 64'(exp_cyc));
        chk("finish_once", 64'(fin), 64'd1);
        chk("done_invariant", 64'(ct || bus.a_q == '0 || bus.b_q == '0), 64'd1);
        repeat (hold) begin
            @(posedge clk); #1;
            chk("hold_o", 64'(bus.o), 64'(exp_o));
            chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
            chk("hold_out_valid", 64'(bus.out_valid), 64'd1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("consumed", 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.stall = 1'b0;
        bus.a = '0; bus.b = '0; bus.op_signed = 1'b0; bus.ct_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_o", 64'(bus.o), 64'd0);
        chk("rst_cycles", 64'(bus.cycles), 64'd0);
        chk("rst_acc_q", 64'(bus.acc_q), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

        run_op(8'd13, 8'd11, 1'b0, 1'b0, -1, 0);
        run_op(8'd13, 8'd11, 1'b0, 1'b1, -1, 0);
        run_op(8'd13, 8'd0, 1'b0, 1'b1, -1, 0);
        run_op(8'd13, 8'd255, 1'b0, 1'b1, -1, 0);
        run_op(8'h80, 8'h80, 1'b1, 1'b0, -1, 0);
        run_op(8'hFD, 8'd5, 1'b1, 1'b0, -1, 0);
        run_op(8'd0, 8'd200, 1'b0, 1'b0, -1, 0);
        run_op(8'd7, 8'd6, 1'b0, 1'b0, 1, 0);
        run_op(8'd13, 8'd11, 1'b0, 1'b0, -1, 3);

        bus.a = 8'd13; bus.b = 8'd11; bus.op_signed = 1'b0; bus.ct_mode = 1'b1; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_out_valid", 64'(bus.out_valid), 64'd0);
        chk("async_o", 64'(bus.o), 64'd0);
        chk("async_acc_q", 64'(bus.acc_q), 64'd0);
        chk("async_b_q", 64'(bus.b_q), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        run_op(8'd2, 8'd3, 1'b0, 1'b0, -1, 0);

        repeat (24) begin
            run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                   ($urandom_range(0, 3) == 0) ? 0 : -1, int'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mul_seq_ct.md
Name: mul_seq_ct

Overview:
- Parametrised sequential shift-and-add multiplier.
- Supports signed/unsigned operands, valid/ready handshakes and a selectable constant-time mode that disables data-dependent early termination.
- Used as the DUT inside two-copy contract miters. It therefore keeps an external stall and exports internal register state and next-state values for shadow-logic predicates.

Parameters:
- WIDTH, 8, operand width in bits (>=2). Product width is 2*WIDTH.
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  operand request
- in_ready  out  1  high when state==IDLE && !stall
- a  in  WIDTH  multiplicand
- b  in  WIDTH  multiplier
- op_signed  in  1  treat a, b as two's complement; sampled on accept
- ct_mode  in  1  1 = constant-time, 0 = early exit; sampled on accept
- stall  in  1  freezes every register (miter alignment)
- out_valid  out  1  result valid (state==DONE)
- out_ready  in  1  result consumed
- o  out  2*WIDTH  product, held stable while out_valid
- cycles  out  CNT_W+1  BUSY cycles consumed by the last operation
- a_q  out  2*WIDTH  current shifted multiplicand magnitude
- b_q  out  WIDTH  current remaining multiplier magnitude
- acc_q  out  2*WIDTH  current accumulator
- a_q_next, b_q_next, acc_q_next  out  as above  next-state values before the stall mux
- finish_next  out  1  next-cycle transition BUSY->DONE

Behaviour:
- Reset (async, any state, including mid-operation):
  - state=IDLE; all registers 0, including o, cycles and the sampled mode flags.
  - out_valid=0; in_ready=1 once rst deasserts and stall=0.
- stall=1 holds all registers; combinational next values are still driven.
- States: IDLE, BUSY, DONE (2-bit encoding, from package).
- IDLE:
  - Accept when in_valid && in_ready.
  - Latch a_q = zero-extended |a|, b_q = |b| (magnitudes only if op_signed, else raw).
  - neg = op_signed & (a[W-1]^b[W-1]); acc_q=0, cnt=0, latch ct_mode. Go to BUSY.
  - |-2^(W-1)| = 2^(W-1) fits in WIDTH unsigned bits.
- BUSY, terminate condition:
  - ct_mode=1: term = (cnt==WIDTH).
  - ct_mode=0: term = (b_q==0) || (a_q==0) || (cnt==WIDTH).
- BUSY, term=0 (iteration):
  - acc_q += b_q[0] ? a_q : 0 (mod 2^(2W)).
  - a_q <<= 1; b_q >>= 1; cnt++.
- BUSY, term=1:
  - o = neg ? -acc_q : acc_q; cycles = cnt+1.
  - Go to DONE, with no add in that cycle.
- Latency: edges from accept edge to out_valid rising = k+1, where k = iterations performed.
  - ct_mode=1: k=WIDTH always, independent of data.
  - ct_mode=0: k = index of highest set bit of |b| plus 1, or 0 if |a|==0 or |b|==0.
- DONE:
  - out_valid=1, o held.
  - On out_ready && !stall go to IDLE. in_ready is 0 in DONE, so back-to-back accept occurs the following cycle at the earliest.
  - finish_next=1 only in BUSY with term=1.
- in_valid while BUSY/DONE is ignored (not queued).
- Invariant for verification: in DONE, a_q!=0 implies b_q==0 unless ct_mode was latched 1.

Decomposition:
- Package mul_seq_pkg holds:
  - state enum (ST_IDLE, ST_BUSY, ST_DONE);
  - function mag(x, signed_en) returning the magnitude;
  - function apply_sign(p, neg) returning p or -p.
- One sub-module, mul_seq_ct_datapath: a_q/b_q/acc_q/cnt registers and next-value logic.
- Top level keeps the FSM, handshake, stall mux and sign/result register.

Test Plan:
- Unsigned, ct_mode=0, WIDTH=8, a=13, b=11 -> o=143, cycles=5, out_valid 5 edges after accept.
- Unsigned, ct_mode=1, a=13, b=11 -> o=143, cycles=9, latency 9; same latency for b=0 and b=255.
- Signed, ct_mode=0, a=-128 (0x80), b=-128 -> o=16384 (0x4000); a=-3, b=5 -> o=0xFFF1 (-15).
- a=0, b=200, ct_mode=0 -> o=0, cycles=1, latency 1; finish_next high exactly one cycle.
- Stall for 3 cycles mid-BUSY (a=7, b=6, ct_mode=0) -> all *_q frozen; latency extends by exactly 3; o=42.
- rst asserted mid-BUSY -> out_valid=0 and o=0 immediately (async); next operation a=2, b=3 yields o=6. Also, out_ready held low in DONE -> o stable and in_ready=0 until consumed.
